uart_rx_deframer: RTL and testbench

Consumes the 100 MHz-synchronised UART receive line produced by the board input stage and recovers 8N1 serial frames into parallel bytes. It uses mid-bit sampling timed from the start-bit falling edge, and it rejects false starts and framing errors. Recovered bytes go out on a valid/ready stream interface to the command/UART bridge logic in the 100 MHz system domain. The input is already metastability-hardened, so this block adds no synchroniser.

---
 rtl/uart_defs.sv | 22 ++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_rx_deframer.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding, line idle level and
// bit-period rounding helper. Used by the receive deframer and the future
// transmitter.
package uart_defs;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_load       load strobe; (re)starts the count from i_load_value
//   i_load_value count to load; expiry occurs i_load_value+1 cycles later
//   o_expire_c   single-cycle expiry flag, decoded from the count register
module uart_bit_timer #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  output logic             o_expire_c
);

  logic [CNT_W-1:0] r_count;
  logic             r_active;

  // Count down once per cycle; stop after reaching zero until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_value;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_expire_c = r_active && (r_count == '0);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receive deframer: mid-bit sampling timed from the start-bit
// falling edge, false-start and framing-error rejection, valid/ready output.
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   rxd            synchronised serial line, idle high
//   m_axis_tdata   received byte
//   m_axis_tvalid  byte available
//   m_axis_tready  consumer accepts byte
//   busy           frame reception in progress
//   frame_error    one-cycle pulse: stop bit sampled low
//   overrun_error  one-cycle pulse: completed byte dropped, output full
module uart_rx_deframer
  import uart_defs::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun_error
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_WIDTH + 1);

  // Too few clocks per bit leaves no room for mid-bit sampling.
  if (CLKS_PER_BIT < 4) begin : g_baud_check
    $error("uart_rx_deframer: CLKS_PER_BIT must be at least 4");
  end

  uart_state_e           r_state;
  uart_state_e           w_next_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_busy;
  logic                  r_frame_error;
  logic                  r_overrun_error;

  logic                  w_timer_load;
  logic [CNT_W-1:0]      w_timer_value;
  logic                  w_expire;
  logic                  w_shift_en;
  logic                  w_idx_clr;
  logic                  w_deliver;
  logic                  w_frame_err;

  uart_bit_timer #(
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_timer_load),
    .i_load_value (w_timer_value),
    .o_expire_c   (w_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_DISARMED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_next_state  = r_state;
    w_timer_load  = 1'b0;
    w_timer_value = '0;
    w_shift_en    = 1'b0;
    w_idx_clr     = 1'b0;
    w_deliver     = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      // Require an idle-high line before hunting for a start bit, so a
      // reset released mid-frame or during a break cannot misframe.
      ST_DISARMED: begin
        if (rxd == LINE_IDLE) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rxd != LINE_IDLE) begin
          w_timer_load  = 1'b1;
          w_timer_value = CNT_W'(HALF_BIT - 1);
          w_next_state  = ST_START;
        end
      end
      // Mid start bit: a high line here was a glitch, not a frame.
      ST_START: begin
        if (w_expire) begin
          if (rxd == LINE_IDLE) begin
            w_next_state = ST_IDLE;
          end else begin
            w_timer_load  = 1'b1;
            w_timer_value = CNT_W'(CLKS_PER_BIT - 1);
            w_idx_clr     = 1'b1;
            w_next_state  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_shift_en    = 1'b1;
          w_timer_load  = 1'b1;
          w_timer_value = CNT_W'(CLKS_PER_BIT - 1);
          if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            w_next_state = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          if (rxd == LINE_IDLE) begin
            w_deliver    = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = ST_DISARMED;
          end
        end
      end
      default: begin
        w_next_state = ST_DISARMED;
      end
    endcase
  end

  // Shift register, bit index, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift         <= '0;
      r_bit_idx       <= '0;
      r_tdata         <= '0;
      r_tvalid        <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_error   <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      if (w_idx_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
      // LSB arrives first, so shift right and insert at the MSB.
      if (w_shift_en) begin
        r_shift <= {rxd, r_shift[DATA_WIDTH-1:1]};
      end

      r_busy <= (w_next_state == ST_START) || (w_next_state == ST_DATA) ||
                (w_next_state == ST_STOP);
      r_frame_error   <= w_frame_err;
      r_overrun_error <= w_deliver && r_tvalid && !m_axis_tready;

      // A new byte may replace the held one only when it leaves this cycle.
      if (w_deliver && (!r_tvalid || m_axis_tready)) begin
        r_tdata  <= r_shift;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = r_busy;
  assign frame_error   = r_frame_error;
  assign overrun_error = r_overrun_error;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer at 16 clocks per bit (1.6 MHz / 100 kBd).
// Frames are driven bit-by-bit on the falling clock edge; a posedge monitor
// logs accepted bytes and pulse events with cycle stamps, and expectations
// come from the frame timing arithmetic (t0 + half bit + n bit periods).
module tb_uart_rx_deframer;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy;
  logic       frame_error;
  logic       overrun_error;

  uart_rx_deframer #(
    .DATA_WIDTH  (8),
    .CLK_FREQ_HZ (1600000),
    .BAUD_RATE   (100000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_error   (frame_error),
    .overrun_error (overrun_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing model: a frame whose start bit is first driven at cycle n0 is
  // stop-sampled mid stop bit, with the result visible at n0 + 8 + 9*16 + 1.
  localparam int BIT = 16;
  localparam int DONE = BIT / 2 + 9 * BIT + 1;

  int n_cmp = 0;
  int n_mis = 0;

  // Monitor state (written only by the monitor).
  int   cyc = 0;
  int   acc_q[$];
  int   acc_cyc[$];
  int   rise_cyc[$];
  int   fe_cyc[$];
  int   ov_cyc[$];
  int   busy_rise[$];
  int   busy_fall[$];
  int   busy_cnt = 0;
  int   valid_cnt = 0;
  int   hold_viol = 0;
  logic prev_tvalid = 1'b0;
  logic prev_acc = 1'b0;
  logic prev_rst = 1'b1;
  logic prev_busy = 1'b0;
  logic [7:0] prev_tdata = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_axis_tvalid && m_axis_tready) begin
      acc_q.push_back(int'(m_axis_tdata));
      acc_cyc.push_back(cyc);
    end
    if (m_axis_tvalid && !prev_tvalid) rise_cyc.push_back(cyc);
    if (frame_error) fe_cyc.push_back(cyc);
    if (overrun_error) ov_cyc.push_back(cyc);
    if (busy) busy_cnt = busy_cnt + 1;
    if (busy && !prev_busy) busy_rise.push_back(cyc);
    if (!busy && prev_busy) busy_fall.push_back(cyc);
    if (m_axis_tvalid) valid_cnt = valid_cnt + 1;
    if (prev_tvalid && !prev_acc && !prev_rst &&
        (!m_axis_tvalid || m_axis_tdata != prev_tdata)) hold_viol = hold_viol + 1;
    prev_tvalid <= m_axis_tvalid;
    prev_acc    <= m_axis_tvalid && m_axis_tready;
    prev_rst    <= rst;
    prev_busy   <= busy;
    prev_tdata  <= m_axis_tdata;
  end

  // Log baselines so each step looks only at its own events.
  int a0, r0, f0, o0, br0, bf0, bc0, v0, h0;
  logic snap_valid, snap_busy, snap_fe, snap_ov;
  logic [7:0] snap_data;

  task automatic mark();
    a0 = acc_q.size(); r0 = rise_cyc.size(); f0 = fe_cyc.size();
    o0 = ov_cyc.size(); br0 = busy_rise.size(); bf0 = busy_fall.size();
    bc0 = busy_cnt; v0 = valid_cnt; h0 = hold_viol;
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 10-bit frame (start, 8 data LSB first, stop). rst is pulsed
  // at frame cycle rst_at when rst_at >= 0, with outputs captured right after.
  task automatic drive_frame(input logic [7:0] b, input logic stop,
                             input int rst_at, output int n0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    n0 = 0;
    for (int k = 0; k < 10 * BIT; k++) begin
      @(negedge clk);
      if (k == 0) n0 = cyc;
      if (rst_at >= 0 && k == rst_at + 1) begin
        snap_valid = m_axis_tvalid; snap_data = m_axis_tdata;
        snap_busy = busy; snap_fe = frame_error; snap_ov = overrun_error;
      end
      rst = (k == rst_at);
      rxd = bits[k / BIT];
    end
  endtask

  int n0, n0a, n0b;
  logic [7:0] rb;
  int exp_q[$];

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tvalid", 32'(m_axis_tvalid), 0);
    chk("reset_tdata", 32'(m_axis_tdata), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_frame_error", 32'(frame_error), 0);
    chk("reset_overrun", 32'(overrun_error), 0);
    rst = 1'b0;
    idle(5);

    // Single frame, consumer always ready.
    m_axis_tready = 1'b1;
    mark();
    drive_frame(8'hA5, 1'b1, -1, n0);
    idle(20);
    chk("a5_count", acc_q.size() - a0, 1);
    chk("a5_data", qat(acc_q, a0), 32'hA5);
    chk("a5_valid_rise", qat(rise_cyc, r0), n0 + DONE);
    chk("a5_valid_len", valid_cnt - v0, 1);
    chk("a5_busy_rise", qat(busy_rise, br0), n0 + 1);
    chk("a5_busy_len", busy_cnt - bc0, DONE - 1);
    chk("a5_errors", (fe_cyc.size() - f0) + (ov_cyc.size() - o0), 0);

    // Back-to-back frames with consumer stalled: second byte overruns.
    m_axis_tready = 1'b0;
    mark();
    drive_frame(8'h3C, 1'b1, -1, n0a);
    drive_frame(8'hC3, 1'b1, -1, n0b);
    idle(10);
    chk("ovr_count", ov_cyc.size() - o0, 1);
    chk("ovr_cycle", qat(ov_cyc, o0), n0b + DONE);
    chk("ovr_tvalid_held", 32'(m_axis_tvalid), 1);
    chk("ovr_tdata_held", 32'(m_axis_tdata), 32'h3C);
    chk("ovr_none_accepted", acc_q.size() - a0, 0);
    m_axis_tready = 1'b1;
    idle(5);
    chk("ovr_acc_count", acc_q.size() - a0, 1);
    chk("ovr_acc_data", qat(acc_q, a0), 32'h3C);
    chk("ovr_tvalid_drop", 32'(m_axis_tvalid), 0);
    chk("ovr_no_frame_err", fe_cyc.size() - f0, 0);
    chk("ovr_hold_stable", hold_viol - h0, 0);

    // False start: 5-cycle low glitch.
    mark();
    @(negedge clk);
    n0 = cyc;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    idle(20);
    chk("glitch_no_valid", rise_cyc.size() - r0, 0);
    chk("glitch_no_err", (fe_cyc.size() - f0) + (ov_cyc.size() - o0), 0);
    chk("glitch_busy_len", busy_cnt - bc0, BIT / 2);
    chk("glitch_busy_fall", qat(busy_fall, bf0), n0 + BIT / 2 + 1);
    mark();
    drive_frame(8'h55, 1'b1, -1, n0);
    idle(5);
    chk("glitch_next_count", acc_q.size() - a0, 1);
    chk("glitch_next_data", qat(acc_q, a0), 32'h55);

    // Framing error followed by a break, then a good frame.
    mark();
    drive_frame(8'h81, 1'b0, -1, n0);
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    idle(10);
    chk("ferr_count", fe_cyc.size() - f0, 1);
    chk("ferr_cycle", qat(fe_cyc, f0), n0 + DONE);
    chk("ferr_no_valid", rise_cyc.size() - r0, 0);
    mark();
    drive_frame(8'h7E, 1'b1, -1, n0);
    idle(5);
    chk("ferr_next_count", acc_q.size() - a0, 1);
    chk("ferr_next_data", qat(acc_q, a0), 32'h7E);
    chk("ferr_next_no_err", fe_cyc.size() - f0, 0);

    // Reset mid data bit 3 (line low) with a byte held in the output.
    m_axis_tready = 1'b0;
    mark();
    drive_frame(8'h99, 1'b1, -1, n0);
    idle(5);
    chk("rst_pre_held", 32'(m_axis_tvalid), 1);
    drive_frame(8'hF0, 1'b1, BIT * 4 + BIT / 2, n0);
    idle(10);
    chk("rst_snap_tvalid", 32'(snap_valid), 0);
    chk("rst_snap_tdata", 32'(snap_data), 0);
    chk("rst_snap_busy", 32'(snap_busy), 0);
    chk("rst_snap_errs", 32'(snap_fe) + 32'(snap_ov), 0);
    chk("rst_no_rearm", busy_rise.size() - br0, 2);
    chk("rst_no_byte", 32'(m_axis_tvalid), 0);
    chk("rst_no_err", (fe_cyc.size() - f0) + (ov_cyc.size() - o0), 0);
    m_axis_tready = 1'b1;
    idle(2);
    mark();
    drive_frame(8'h12, 1'b1, -1, n0);
    idle(5);
    chk("rst_next_count", acc_q.size() - a0, 1);
    chk("rst_next_data", qat(acc_q, a0), 32'h12);

    // Consume on the exact cycle the next byte is delivered.
    m_axis_tready = 1'b0;
    mark();
    fork
      begin
        drive_frame(8'h01, 1'b1, -1, n0a);
        drive_frame(8'h02, 1'b1, -1, n0b);
      end
      begin
        repeat (10 * BIT + DONE) @(negedge clk);
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        m_axis_tready = 1'b1;
      end
    join
    idle(5);
    chk("swap_count", acc_q.size() - a0, 2);
    chk("swap_first", qat(acc_q, a0), 32'h01);
    chk("swap_second", qat(acc_q, a0 + 1), 32'h02);
    chk("swap_first_cyc", qat(acc_cyc, a0), n0b + DONE - 1);
    chk("swap_second_cyc", qat(acc_cyc, a0 + 1), n0b + DONE + 3);
    chk("swap_rise_count", rise_cyc.size() - r0, 1);
    chk("swap_rise_cyc", qat(rise_cyc, r0), n0a + DONE);
    chk("swap_valid_len", valid_cnt - v0, (n0b + DONE + 3) - (n0a + DONE) + 1);
    chk("swap_no_overrun", ov_cyc.size() - o0, 0);

    // Random bytes with random idle gaps, consumer always ready.
    m_axis_tready = 1'b1;
    mark();
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      exp_q.push_back(int'(rb));
      drive_frame(rb, 1'b1, -1, n0);
      idle(int'($urandom_range(0, 12)));
    end
    idle(5);
    chk("rand_count", acc_q.size() - a0, 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("rand_byte%0d", i), qat(acc_q, a0 + i), exp_q[i]);
    end
    chk("rand_no_err", (fe_cyc.size() - f0) + (ov_cyc.size() - o0), 0);
    chk("hold_stable_total", hold_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
